// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter between the MEM stage and the debug readout port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_STEAL = 2'd1,
    ARB_HALT  = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 8;

  // Counter only has to reach STARVE_MAX-1, so clog2(STARVE_MAX) bits suffice.
  function automatic int starve_cnt_w(input int starve_max);
    return (starve_max <= 2) ? 1 : $clog2(starve_max);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles in which the CPU blocks a pending debug read.
module dmem_arb_starve_cnt #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [W-1:0] TC = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU MEM stage has priority, debug reads fill idle cycles,
// steal a stall cycle when starved, and own the RAM while the program is halted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              halted,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output arb_state_e        arb_state
);

  localparam int CNT_W = starve_cnt_w(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic              cpu_stall_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_pend;
  logic              capture;
  logic              conflict;
  logic              cnt_clr;
  logic              starve_tc;

  // Debug handshake: dbg_req is a level held with a stable dbg_addr until dbg_ack pulses;
  // masking with the ack register keeps a held request from being served twice.
  assign dbg_pend = dbg_req & ~dbg_ack_q;
  assign conflict = (state_q == ARB_RUN) & cpu_req & dbg_pend;
  assign cnt_clr  = capture | ~dbg_req | (state_q != ARB_RUN);

  dmem_arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (conflict),
    .clr_i (cnt_clr),
    .tc_o  (starve_tc)
  );

  always_comb begin
    capture  = 1'b0;
    ram_addr = cpu_addr;
    ram_we   = 1'b0;
    state_d  = state_q;
    case (state_q)
      ARB_RUN: begin
        if (cpu_req) begin
          ram_we = cpu_we;
        end else if (dbg_pend) begin
          ram_addr = dbg_addr;
          capture  = 1'b1;
        end
        if (halted)                      state_d = ARB_HALT;
        else if (conflict && starve_tc)  state_d = ARB_STEAL;
      end
      ARB_STEAL: begin
        ram_addr = dbg_addr;
        capture  = 1'b1;
        state_d  = halted ? ARB_HALT : ARB_RUN;
      end
      ARB_HALT: begin
        if (dbg_pend) begin
          ram_addr = dbg_addr;
          capture  = 1'b1;
        end
        state_d = halted ? ARB_HALT : ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  // Stall is registered alongside the state so it never depends combinationally on cpu_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_RUN;
      cpu_stall_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_stall_q <= (state_d != ARB_RUN);
      dbg_ack_q   <= capture;
      if (capture) begin
        dbg_rdata_q <= ram_rdata;
      end
    end
  end

  assign cpu_rdata = ram_rdata;
  assign ram_wdata = cpu_wdata;
  assign cpu_stall = cpu_stall_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign arb_state = state_q;

endmodule
